game_status_display: RTL

//  Parametrised score/status front panel for the stacking game; successor to the fixed LEDR score/chance wiring.

---
 rtl/game_status_display_pkg.sv | 48 ++++
 rtl/game_status_display_if.sv | 26 ++
 rtl/game_status_display_bin2bcd.sv | 74 +++++++
 rtl/game_status_display.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/game_status_display_pkg.sv
// Shared encodings and helpers for the score/status front panel.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package game_display_pkg;

    // game_status encodings driven by game_logic_top
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Physical HEX digits on the board
    localparam int MAX_DIGITS = 6;

    // Converter FSM state encoding
    typedef logic [1:0] conv_state_t;
    localparam conv_state_t CS_IDLE  = 2'd0;
    localparam conv_state_t CS_LOAD  = 2'd1;
    localparam conv_state_t CS_SHIFT = 2'd2;
    localparam conv_state_t CS_DONE  = 2'd3;

    // ceil(bits*log10(2)) + 1 decimal digits; log10(2) approximated as 0.30103,
    // never an exact integer product for bits > 0 so the ceiling is safe.
    function automatic int bcd_digits(input int bits);
        return (bits * 30103 + 99999) / 100000 + 1;
    endfunction

    // BCD digit -> gfedcba, active-low; non-decimal codes show blank
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/game_status_display_if.sv
// Bundle between game_logic_top (master) and the front panel (slave).
// Latency: n/a (wires only).
// Backpressure: none; score/chances/status are level signals sampled every cycle.
// Ports: score, chances, game_status (master->slave); hex, ledr, busy (slave->master).
interface game_status_display_if #(
    parameter int SCORE_W  = 10,
    parameter int CHANCE_W = 3,
    parameter int LED_W    = 10
);
    logic [SCORE_W-1:0]  score;
    logic [CHANCE_W-1:0] chances;
    logic [1:0]          game_status;
    logic [41:0]         hex;
    logic [LED_W-1:0]    ledr;
    logic                busy;

    modport master (
        output score, chances, game_status,
        input  hex, ledr, busy
    );

    modport slave (
        input  score, chances, game_status,
        output hex, ledr, busy
    );
endinterface

// File: rtl/game_status_display_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter (bin2bcd_seq).
// Latency: start seen in IDLE -> done after IN_W+2 further cycles (LOAD, IN_W x SHIFT, DONE).
// Backpressure: start is ignored while busy; din is sampled once, in LOAD (ack high).
// Ports: clk, resetn, start, din in; ack (LOAD), busy (SHIFT/DONE), done (DONE), bcd out.
module bin2bcd_seq
    import game_display_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int BCD_W = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [IN_W-1:0]  din,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int CNT_W = $clog2(IN_W + 1);

    conv_state_t      state;
    logic [IN_W-1:0]  sr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt;

    // add-3 correction on every digit >= 5 before the shift
    always_comb begin
        adj = acc;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CS_IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                CS_IDLE: begin
                    if (start)
                        state <= CS_LOAD;
                end
                CS_LOAD: begin
                    sr    <= din;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= CS_SHIFT;
                end
                CS_SHIFT: begin
                    acc <= {adj[BCD_W-2:0], sr[IN_W-1]};
                    sr  <= sr << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(IN_W - 1))
                        state <= CS_DONE;
                end
                default: begin
                    state <= CS_IDLE;
                end
            endcase
        end
    end

    assign ack  = (state == CS_LOAD);
    assign busy = (state == CS_SHIFT) || (state == CS_DONE);
    assign done = (state == CS_DONE);
    assign bcd  = acc;

endmodule

// File: rtl/game_status_display.sv
// Score/status front panel: BCD score on HEX, chances thermometer on LEDR, blink on game over.
// Latency: score change -> hex SCORE_W+3 cycles; chances/status -> ledr/hex 1 cycle.
// Backpressure: none; score changes mid-conversion are picked up by a re-conversion afterwards.
// Ports: clk, resetn; io (slave): score, chances, game_status in; hex {HEX5..HEX0}, ledr, busy out.
module game_status_display
    import game_display_pkg::*;
#(
    parameter int SCORE_W    = 10,
    parameter int NUM_DIGITS = 4,
    parameter int CHANCE_W   = 3,
    parameter int LED_W      = 10,
    parameter int BLINK_DIV  = 25000000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                clk,
    input  logic                resetn,
    game_status_display_if.slave io
);
    localparam int BCD_D = bcd_digits(SCORE_W);
    localparam int BCD_W = 4 * BCD_D;
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam int DIG_W = 4 * MAX_DIGITS;

    logic [SCORE_W-1:0] last_score;
    logic               pending;
    logic               conv_start, conv_ack, conv_busy, conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [DIG_W-1:0]   conv_digits, nines;
    logic               conv_over;

    logic [DIG_W-1:0]   shown_q, shown_nxt;
    logic               shown_vld_q, shown_vld_nxt;
    logic               ovf_q, ovf_nxt;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_nxt;
    logic               phase_q, phase_nxt;
    logic [1:0]         status_q;
    logic [41:0]        hex_q, hex_nxt;
    logic [LED_W-1:0]   ledr_q, ledr_nxt;
    logic [LED_W-2:0]   therm;
    logic [3:0]         dig;
    logic               hi_nz, lz, blink_off;

    // pending forces one conversion of whatever score is present after reset
    assign conv_start = pending || (io.score != last_score);

    bin2bcd_seq #(.IN_W(SCORE_W), .BCD_W(BCD_W)) u_bin2bcd (
        .clk    (clk),
        .resetn (resetn),
        .start  (conv_start),
        .din    (io.score),
        .ack    (conv_ack),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    // split converter result into shown digits and an overflow indication
    always_comb begin
        conv_digits = '0;
        nines       = '0;
        conv_over   = 1'b0;
        for (int j = 0; j < MAX_DIGITS && j < BCD_D; j++) begin
            if (j < NUM_DIGITS)
                conv_digits[4*j +: 4] = conv_bcd[4*j +: 4];
        end
        for (int j = 0; j < BCD_D; j++) begin
            if (j >= NUM_DIGITS && conv_bcd[4*j +: 4] != 4'd0)
                conv_over = 1'b1;
        end
        for (int j = 0; j < MAX_DIGITS; j++) begin
            if (j < NUM_DIGITS)
                nines[4*j +: 4] = 4'd9;
        end
    end

    // Next-state for everything feeding the output registers, so hex/ledr
    // change on the same edge as the commit / blink phase they reflect.
    always_comb begin
        shown_nxt     = shown_q;
        shown_vld_nxt = shown_vld_q;
        ovf_nxt       = ovf_q;
        if (conv_done) begin
            shown_vld_nxt = 1'b1;
            ovf_nxt       = conv_over;
            shown_nxt     = conv_over ? nines : conv_digits;
        end

        if (io.game_status != status_q ||
            !(io.game_status == ST_WIN || io.game_status == ST_LOSE)) begin
            blk_cnt_nxt = '0;
            phase_nxt   = 1'b1;
        end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_nxt = '0;
            phase_nxt   = ~phase_q;
        end else begin
            blk_cnt_nxt = blk_cnt_q + 1'b1;
            phase_nxt   = phase_q;
        end

        blink_off = (io.game_status == ST_LOSE) && !phase_nxt;

        // walk from the top digit so hi_nz knows about all higher digits
        hex_nxt = {MAX_DIGITS{SEG_BLANK}};
        hi_nz   = 1'b0;
        dig     = '0;
        lz      = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            dig = shown_nxt[4*i +: 4];
            if (i < NUM_DIGITS) begin
                if (dig != 4'd0)
                    hi_nz = 1'b1;
                lz = (LZ_BLANK != 0) && (i > 0) && !hi_nz;
                if (shown_vld_nxt && !lz && !blink_off)
                    hex_nxt[7*i +: 7] = seg7_decode(dig);
            end
        end

        therm = '0;
        for (int k = 0; k < LED_W - 1; k++)
            therm[k] = (k < int'(io.chances));
        if (io.game_status == ST_WIN)
            therm = phase_nxt ? '1 : '0;
        ledr_nxt = {ovf_nxt, therm};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_score  <= '0;
            pending     <= 1'b1;
            shown_q     <= '0;
            shown_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            blk_cnt_q   <= '0;
            phase_q     <= 1'b1;
            status_q    <= ST_IDLE;
            hex_q       <= {MAX_DIGITS{SEG_BLANK}};
            ledr_q      <= '0;
        end else begin
            if (conv_ack) begin
                last_score <= io.score;
                pending    <= 1'b0;
            end
            shown_q     <= shown_nxt;
            shown_vld_q <= shown_vld_nxt;
            ovf_q       <= ovf_nxt;
            blk_cnt_q   <= blk_cnt_nxt;
            phase_q     <= phase_nxt;
            status_q    <= io.game_status;
            hex_q       <= hex_nxt;
            ledr_q      <= ledr_nxt;
        end
    end

    assign io.hex  = hex_q;
    assign io.ledr = ledr_q;
    assign io.busy = conv_busy;

endmodule
